// File: rtl/acs_butterfly.sv
// Viterbi add-compare-select butterfly: two candidate sums per successor state, min select,
// optional metric normalization with clamp/saturate, and a one-deep valid/ready output register.
module acs_butterfly #(
    parameter int PM_W     = 8,
    parameter int NORM_SUB = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [1:0]      bm_0,
    input  logic [1:0]      bm_1,
    input  logic            norm_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PM_W-1:0] pm_out_0,
    output logic [PM_W-1:0] pm_out_1,
    output logic            dec_0,
    output logic            dec_1,
    output logic            pm_hi,
    output logic            sat_flag
);

    localparam logic [PM_W:0] SUB = (PM_W+1)'(NORM_SUB);

    function automatic logic [PM_W:0] ext_bm(input logic [1:0] bm);
        return {{(PM_W-1){1'b0}}, bm};
    endfunction

    // Subtract the normalization constant, clamping at zero instead of wrapping.
    function automatic logic [PM_W:0] normalize(input logic [PM_W:0] v, input logic en);
        if (!en)
            return v;
        if (v < SUB)
            return '0;
        return v - SUB;
    endfunction

    logic [PM_W:0]   s_a0, s_b1, s_a1, s_b0;
    logic [PM_W:0]   sel_0, sel_1, r_0, r_1;
    logic            dec_0_nxt, dec_1_nxt, sat_0, sat_1, accept;
    logic [PM_W-1:0] val_0, val_1;

    assign s_a0 = {1'b0, pm_a} + ext_bm(bm_0);
    assign s_b1 = {1'b0, pm_b} + ext_bm(bm_1);
    assign s_a1 = {1'b0, pm_a} + ext_bm(bm_1);
    assign s_b0 = {1'b0, pm_b} + ext_bm(bm_0);

    // Strict less-than so a tie keeps the pm_a path with decision 0.
    assign dec_0_nxt = (s_b1 < s_a0);
    assign dec_1_nxt = (s_b0 < s_a1);
    assign sel_0     = dec_0_nxt ? s_b1 : s_a0;
    assign sel_1     = dec_1_nxt ? s_b0 : s_a1;

    assign r_0   = normalize(sel_0, norm_en);
    assign r_1   = normalize(sel_1, norm_en);
    assign sat_0 = r_0[PM_W];
    assign sat_1 = r_1[PM_W];
    assign val_0 = sat_0 ? {PM_W{1'b1}} : r_0[PM_W-1:0];
    assign val_1 = sat_1 ? {PM_W{1'b1}} : r_1[PM_W-1:0];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign pm_hi    = pm_out_0[PM_W-1] && pm_out_1[PM_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pm_out_0  <= '0;
            pm_out_1  <= '0;
            dec_0     <= 1'b0;
            dec_1     <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            pm_out_0  <= val_0;
            pm_out_1  <= val_1;
            dec_0     <= dec_0_nxt;
            dec_1     <= dec_1_nxt;
            sat_flag  <= sat_flag || sat_0 || sat_1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acs_butterfly.sv
// Self-checking bench for acs_butterfly: directed vectors, backpressure, async reset,
// and randomized traffic against an arithmetic reference model.
module tb_acs_butterfly;

    localparam int PM_W     = 8;
    localparam int NORM_SUB = 128;
    localparam int MAXV     = (1 << PM_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [PM_W-1:0] pm_a = '0;
    logic [PM_W-1:0] pm_b = '0;
    logic [1:0]      bm_0 = '0;
    logic [1:0]      bm_1 = '0;
    logic            norm_en = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [PM_W-1:0] pm_out_0, pm_out_1;
    logic            dec_0, dec_1, pm_hi, sat_flag;

    int n_tests = 0;
    int n_fail  = 0;

    acs_butterfly #(.PM_W(PM_W), .NORM_SUB(NORM_SUB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pm_a(pm_a), .pm_b(pm_b), .bm_0(bm_0), .bm_1(bm_1), .norm_en(norm_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .pm_out_0(pm_out_0), .pm_out_1(pm_out_1),
        .dec_0(dec_0), .dec_1(dec_1), .pm_hi(pm_hi), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Reference ACS: pick the smaller sum (pm_a path on ties), normalize, clamp, saturate.
    function automatic void ref_acs(input int a, input int b, input int m0, input int m1,
                                    input bit n, output int r0, output int r1,
                                    output bit d0, output bit d1, output bit s);
        int cand_a0, cand_b1, cand_a1, cand_b0;
        cand_a0 = a + m0;  cand_b1 = b + m1;
        cand_a1 = a + m1;  cand_b0 = b + m0;
        d0 = cand_b1 < cand_a0;
        d1 = cand_b0 < cand_a1;
        r0 = d0 ? cand_b1 : cand_a0;
        r1 = d1 ? cand_b0 : cand_a1;
        if (n) begin
            r0 = (r0 - NORM_SUB < 0) ? 0 : r0 - NORM_SUB;
            r1 = (r1 - NORM_SUB < 0) ? 0 : r1 - NORM_SUB;
        end
        s = 1'b0;
        if (r0 > MAXV) begin r0 = MAXV; s = 1'b1; end
        if (r1 > MAXV) begin r1 = MAXV; s = 1'b1; end
    endfunction

    task automatic set_in(input bit v, input int a, input int b, input int m0, input int m1,
                          input bit n);
        in_valid = v;
        pm_a     = PM_W'(a);
        pm_b     = PM_W'(b);
        bm_0     = 2'(m0);
        bm_1     = 2'(m1);
        norm_en  = n;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({out_valid, pm_out_0, pm_out_1, dec_0, dec_1, sat_flag, pm_hi} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%0b p0=%0d p1=%0d d=%0b%0b sat=%0b hi=%0b, want all 0",
                     out_valid, pm_out_0, pm_out_1, dec_0, dec_1, sat_flag, pm_hi);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        // a, b, bm0, bm1, norm, exp0, exp1, d0, d1, hi, sat
        int tv [7][11] = '{
            '{ 10,  12, 2, 0, 0,  12,  10, 0, 0, 0, 0},
            '{ 20,   5, 1, 2, 0,   7,   6, 1, 1, 0, 0},
            '{200, 210, 0, 1, 1,  72,  73, 0, 0, 0, 0},
            '{ 10,  12, 2, 0, 1,   0,   0, 0, 0, 0, 0},
            '{255, 255, 2, 2, 0, 255, 255, 0, 0, 1, 1},
            '{ 10,  12, 2, 0, 0,  12,  10, 0, 0, 0, 1},
            '{255, 255, 2, 2, 1, 129, 129, 0, 0, 1, 1}
        };
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4] != 0);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || pm_out_0 !== PM_W'(tv[i][5]) || pm_out_1 !== PM_W'(tv[i][6])
                || dec_0 !== tv[i][7][0] || dec_1 !== tv[i][8][0]
                || pm_hi !== tv[i][9][0] || sat_flag !== tv[i][10][0]) begin
                n_fail++;
                $display("FAIL vector_%0d: got ov=%0b p0=%0d p1=%0d d=%0b%0b hi=%0b sat=%0b, want ov=1 p0=%0d p1=%0d d=%0d%0d hi=%0d sat=%0d",
                         i, out_valid, pm_out_0, pm_out_1, dec_0, dec_1, pm_hi, sat_flag,
                         tv[i][5], tv[i][6], tv[i][7], tv[i][8], tv[i][9], tv[i][10]);
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_clears_valid: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 30, 40, 1, 2, 1'b0);
        step();
        n_tests++;
        if (out_valid !== 1'b1 || pm_out_0 !== 8'd31 || pm_out_1 !== 8'd32) begin
            n_fail++;
            $display("FAIL bp_first: got ov=%0b p0=%0d p1=%0d want ov=1 p0=31 p1=32",
                     out_valid, pm_out_0, pm_out_1);
        end
        set_in(1'b1, 100, 50, 0, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready_%0d: got %0b want 0", c, in_ready);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b1 || pm_out_0 !== 8'd31 || pm_out_1 !== 8'd32
                || dec_0 !== 1'b0 || dec_1 !== 1'b0 || pm_hi !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got ov=%0b p0=%0d p1=%0d d=%0b%0b want ov=1 p0=31 p1=32 d=00",
                         c, out_valid, pm_out_0, pm_out_1, dec_0, dec_1);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %0b want 1", in_ready);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || pm_out_0 !== 8'd50 || pm_out_1 !== 8'd50
            || dec_0 !== 1'b1 || dec_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain_accept: got ov=%0b p0=%0d p1=%0d d=%0b%0b want ov=1 p0=50 p1=50 d=11",
                     out_valid, pm_out_0, pm_out_1, dec_0, dec_1);
        end
        in_valid = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_duplicate: got ov=%0b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_in(1'b1, 255, 255, 2, 2, 1'b0);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, pm_out_0, pm_out_1, dec_0, dec_1, sat_flag, pm_hi} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got ov=%0b p0=%0d p1=%0d sat=%0b hi=%0b, want all 0 before edge",
                     out_valid, pm_out_0, pm_out_1, sat_flag, pm_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 20, 5, 1, 2, 1'b0);
        step();
        n_tests++;
        if (out_valid !== 1'b1 || pm_out_0 !== 8'd7 || pm_out_1 !== 8'd6 || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_accept: got ov=%0b p0=%0d p1=%0d sat=%0b want ov=1 p0=7 p1=6 sat=0",
                     out_valid, pm_out_0, pm_out_1, sat_flag);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        bit ev = 1'b0, ed0 = 1'b0, ed1 = 1'b0, esat = 1'b0, acc, nd0, nd1, ns;
        int e0 = 0, e1 = 0, n0, n1, a, b, m0, m1;
        bit n;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(240, MAXV) : $urandom_range(0, MAXV);
            b  = ($urandom_range(0, 3) == 0) ? $urandom_range(240, MAXV) : $urandom_range(0, MAXV);
            m0 = $urandom_range(0, 2);
            m1 = $urandom_range(0, 2);
            n  = ($urandom_range(0, 3) == 0);
            set_in($urandom_range(0, 9) < 7, a, b, m0, m1, n);
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            acc = in_valid && (!ev || out_ready);
            n_tests++;
            if (in_ready !== (!ev || out_ready)) begin
                n_fail++;
                $display("FAIL rand_in_ready cyc%0d: got %0b want %0b", cyc, in_ready, !ev || out_ready);
            end
            if (acc) begin
                ref_acs(a, b, m0, m1, n, n0, n1, nd0, nd1, ns);
                ev = 1'b1; e0 = n0; e1 = n1; ed0 = nd0; ed1 = nd1; esat = esat | ns;
            end else if (out_ready) begin
                ev = 1'b0;
            end
            step();
            n_tests++;
            if (out_valid !== ev || pm_out_0 !== PM_W'(e0) || pm_out_1 !== PM_W'(e1)
                || dec_0 !== ed0 || dec_1 !== ed1 || sat_flag !== esat
                || pm_hi !== (e0 >= 128 && e1 >= 128)) begin
                n_fail++;
                $display("FAIL rand_outputs cyc%0d: got ov=%0b p0=%0d p1=%0d d=%0b%0b sat=%0b hi=%0b want ov=%0b p0=%0d p1=%0d d=%0b%0b sat=%0b",
                         cyc, out_valid, pm_out_0, pm_out_1, dec_0, dec_1, sat_flag, pm_hi,
                         ev, e0, e1, ed0, ed1, esat);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
